// File: rtl/ntt_pkg.sv
// Shared constants and types for the Kyber NTT twiddle sequencer.
// Optional feature macro: NTT_SEQ_INV_NEG_EN (see ntt_twiddle_sequencer.sv).
package ntt_pkg;

    localparam int unsigned N_COEF     = 256;
    localparam int unsigned N_LAYERS   = 7;
    localparam int unsigned N_BFLY     = 896;
    localparam int unsigned K_FWD_INIT = 1;
    localparam int unsigned K_INV_INIT = 127;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/ntt_sched_counter.sv
// Layer / group-start / offset / twiddle-index counters for the 7-layer NTT schedule.
// k_next is the value k takes after an advance, used to pre-address the twiddle ROM.
module ntt_sched_counter
    import ntt_pkg::*;
#(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned AW    = 7
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             load_mode,
    input  logic             advance,
    output logic             mode_q,
    output logic [2:0]       layer,
    output logic [IDX_W-1:0] idx_a,
    output logic [IDX_W-1:0] idx_b,
    output logic [AW-1:0]    k,
    output logic [AW-1:0]    k_next,
    output logic             last
);

    logic [2:0]       layer_q;
    logic [IDX_W-1:0] start_q;
    logic [IDX_W-1:0] j_q;
    logic [AW-1:0]    k_q;
    logic [IDX_W-1:0] len;
    logic             group_end;
    logic             layer_end;

    // Forward halves the butterfly span each layer; inverse doubles it.
    always_comb begin
        if (mode_q == MODE_INV) begin
            len = IDX_W'(2) << layer_q;
        end else begin
            len = IDX_W'(N_COEF / 2) >> layer_q;
        end
    end

    assign group_end = (j_q == len - IDX_W'(1));
    // Next group start would reach N_COEF; widened by one bit to see the overflow.
    assign layer_end = (({1'b0, start_q} + {len, 1'b0}) == (IDX_W + 1)'(N_COEF));
    assign last      = group_end && layer_end && (layer_q == 3'(N_LAYERS - 1));

    always_comb begin
        k_next = k_q;
        if (group_end) begin
            if (mode_q == MODE_INV) begin
                k_next = k_q - AW'(1);
            end else begin
                k_next = k_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mode_q  <= MODE_FWD;
            layer_q <= '0;
            start_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else if (load) begin
            mode_q  <= load_mode;
            layer_q <= '0;
            start_q <= '0;
            j_q     <= '0;
            k_q     <= (load_mode == MODE_INV) ? AW'(K_INV_INIT) : AW'(K_FWD_INIT);
        end else if (advance) begin
            k_q <= k_next;
            if (group_end) begin
                j_q <= '0;
                if (layer_end) begin
                    start_q <= '0;
                    layer_q <= layer_q + 3'd1;
                end else begin
                    start_q <= start_q + {len[IDX_W-2:0], 1'b0};
                end
            end else begin
                j_q <= j_q + IDX_W'(1);
            end
        end
    end

    assign layer = layer_q;
    assign idx_a = start_q + j_q;
    assign idx_b = start_q + j_q + len;
    assign k     = k_q;

endmodule

// File: rtl/ntt_twiddle_sequencer.sv
// Drives the registered twiddle ROM and emits one butterfly descriptor per handshake.
// Macro NTT_SEQ_INV_NEG_EN: negate the twiddle in inverse mode.
module ntt_twiddle_sequencer
    import ntt_pkg::*;
#(
    parameter int unsigned TW_W  = 16,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned AW    = 7
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start,
    input  logic             mode,
    output logic [AW-1:0]    rom_addr,
    input  logic [TW_W-1:0]  rom_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx_a,
    output logic [IDX_W-1:0] out_idx_b,
    output logic [2:0]       out_layer,
    output logic [TW_W-1:0]  out_tw,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic             load;
    logic             hs;
    logic             last;
    logic             mode_q;
    logic [2:0]       layer;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic [AW-1:0]    k;
    logic [AW-1:0]    k_next;

    assign load = (state_q == IDLE) && start;
    assign hs   = (state_q == RUN) && out_ready;

    ntt_sched_counter #(
        .IDX_W (IDX_W),
        .AW    (AW)
    ) u_cnt (
        .clk       (clk),
        .srst      (srst),
        .load      (load),
        .load_mode (mode),
        .advance   (hs),
        .mode_q    (mode_q),
        .layer     (layer),
        .idx_a     (idx_a),
        .idx_b     (idx_b),
        .k         (k),
        .k_next    (k_next),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // rom_addr looks one descriptor ahead on a handshake so the ROM's registered
    // output always matches the descriptor presented, whatever out_ready does.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rom_addr  = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d  = PRIME;
                    rom_addr = (mode == MODE_INV) ? AW'(K_INV_INIT) : AW'(K_FWD_INIT);
                end
            end
            PRIME: begin
                rom_addr = k;
                state_d  = RUN;
            end
            RUN: begin
                out_valid = 1'b1;
                rom_addr  = hs ? k_next : k;
                if (hs && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_idx_a = out_valid ? idx_a : '0;
    assign out_idx_b = out_valid ? idx_b : '0;
    assign out_layer = out_valid ? layer : '0;

`ifdef NTT_SEQ_INV_NEG_EN
    assign out_tw = (mode_q == MODE_INV) ? (TW_W'(0) - rom_dout) : rom_dout;
`else
    assign out_tw = rom_dout;
`endif

endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// Directed, table-driven bench for ntt_twiddle_sequencer with a registered ROM model.
// Honours NTT_SEQ_INV_NEG_EN when computing expected twiddles.
module tb_ntt_twiddle_sequencer;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [6:0]  rom_addr;
    logic [15:0] rom_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_idx_a;
    logic [7:0]  out_idx_b;
    logic [2:0]  out_layer;
    logic [15:0] out_tw;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_dout <= {9'h0, rom_addr};

    ntt_twiddle_sequencer #(
        .TW_W  (16),
        .IDX_W (8),
        .AW    (7)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .start     (start),
        .mode      (mode),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx_a (out_idx_a),
        .out_idx_b (out_idx_b),
        .out_layer (out_layer),
        .out_tw    (out_tw),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  layer;
        logic [15:0] tw;
    } desc_t;

    typedef struct {
        logic        m;
        int unsigned n;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  layer;
        int unsigned k;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    desc_t       cap[896];
    int unsigned hs_cnt;
    int          first_valid;
    int          first_hs;
    int          last_hs;
    int unsigned done_cnt;
    int          done_cyc;

    function automatic logic [15:0] tw_of(input logic m, input int unsigned k);
`ifdef NTT_SEQ_INV_NEG_EN
        if (m) return 16'(0 - k);
`endif
        return 16'(k);
    endfunction

    // Closed-form schedule: layer L, position mi inside the layer.
    function automatic desc_t model(input logic m, input int unsigned n);
        int unsigned L, mi, len, g, j, st, k;
        desc_t d;
        L  = n / 128;
        mi = n % 128;
        if (!m) begin
            len = 128 >> L;
            k   = (1 << L) + mi / len;
        end else begin
            len = 2 << L;
            k   = 127 - mi / len;
            for (int unsigned l = 0; l < L; l++) k -= (64 >> l);
        end
        g  = mi / len;
        j  = mi % len;
        st = g * 2 * len;
        d.a     = 8'(st + j);
        d.b     = 8'(st + j + len);
        d.layer = 3'(L);
        d.tw    = tw_of(m, k);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_xfer(input logic m, input bit bp, input bit poke);
        desc_t cur, prev;
        bit    prev_stall;
        bit    finished;
        hs_cnt      = 0;
        done_cnt    = 0;
        first_valid = -1;
        first_hs    = -1;
        last_hs     = -1;
        done_cyc    = -1;
        prev_stall  = 0;
        finished    = 0;
        prev        = '0;
        mode        = m;
        start       = 1'b1;
        out_ready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 1; c < 4000 && !finished; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            mode  = ~m;  // must be ignored once running
            cur = '{a: out_idx_a, b: out_idx_b, layer: out_layer, tw: out_tw};
            if (prev_stall) begin
                chk("stall_hold", {out_valid, cur}, {1'b1, prev});
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (poke && ((out_valid && hs_cnt == 400) || done)) start = 1'b1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (hs_cnt < 896) cap[hs_cnt] = cur;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                hs_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur;
            if (!busy && c > 2) finished = 1;
        end
        chk("xfer_timeout", 64'(finished), 64'd1);
        out_ready = 1'b0;
    endtask

    task automatic chk_seq(input string nm, input logic m);
        int unsigned bad = 0;
        for (int unsigned n = 0; n < 896; n++) begin
            if (cap[n] !== model(m, n)) begin
                if (bad == 0)
                    $display("FAIL %s: descriptor %0d got 0x%0h expected 0x%0h",
                             nm, n, cap[n], model(m, n));
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    vec_t vecs[7];
    desc_t exp_d;

    initial begin
        vecs[0] = '{m: 1'b0, n: 0,   a: 8'd0,   b: 8'd128, layer: 3'd0, k: 1};
        vecs[1] = '{m: 1'b0, n: 127, a: 8'd127, b: 8'd255, layer: 3'd0, k: 1};
        vecs[2] = '{m: 1'b0, n: 128, a: 8'd0,   b: 8'd64,  layer: 3'd1, k: 2};
        vecs[3] = '{m: 1'b0, n: 895, a: 8'd253, b: 8'd255, layer: 3'd6, k: 127};
        vecs[4] = '{m: 1'b1, n: 0,   a: 8'd0,   b: 8'd2,   layer: 3'd0, k: 127};
        vecs[5] = '{m: 1'b1, n: 1,   a: 8'd1,   b: 8'd3,   layer: 3'd0, k: 127};
        vecs[6] = '{m: 1'b1, n: 895, a: 8'd127, b: 8'd255, layer: 3'd6, k: 1};

        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_state", {out_valid, busy, done, rom_addr, out_idx_a, out_idx_b, out_layer},
            64'd0);

        // Forward, no backpressure, start pokes during RUN and DONE.
        run_xfer(1'b0, 0, 1);
        chk("fwd_count", 64'(hs_cnt), 64'd896);
        chk("fwd_first_valid_cycle", 64'(first_valid), 64'd2);
        chk("fwd_no_bubble", 64'(last_hs - first_hs), 64'd895);
        chk("fwd_done_once", 64'(done_cnt), 64'd1);
        chk("fwd_done_timing", 64'(done_cyc), 64'(last_hs + 1));
        chk_seq("fwd_sequence", 1'b0);
        foreach (vecs[i]) begin
            if (!vecs[i].m) begin
                exp_d = '{a: vecs[i].a, b: vecs[i].b, layer: vecs[i].layer,
                          tw: tw_of(1'b0, vecs[i].k)};
                chk($sformatf("fwd_vec_%0d", vecs[i].n), 64'(cap[vecs[i].n]), 64'(exp_d));
            end
        end

        // Inverse, no backpressure.
        run_xfer(1'b1, 0, 0);
        chk("inv_count", 64'(hs_cnt), 64'd896);
        chk("inv_first_valid_cycle", 64'(first_valid), 64'd2);
        chk("inv_done_once", 64'(done_cnt), 64'd1);
        chk_seq("inv_sequence", 1'b1);
        foreach (vecs[i]) begin
            if (vecs[i].m) begin
                exp_d = '{a: vecs[i].a, b: vecs[i].b, layer: vecs[i].layer,
                          tw: tw_of(1'b1, vecs[i].k)};
                chk($sformatf("inv_vec_%0d", vecs[i].n), 64'(cap[vecs[i].n]), 64'(exp_d));
            end
        end

        // Random backpressure in both modes.
        run_xfer(1'b0, 1, 0);
        chk("fwd_bp_count", 64'(hs_cnt), 64'd896);
        chk_seq("fwd_bp_sequence", 1'b0);
        run_xfer(1'b1, 1, 0);
        chk("inv_bp_count", 64'(hs_cnt), 64'd896);
        chk_seq("inv_bp_sequence", 1'b1);

        // Synchronous reset at handshake 300.
        hs_cnt    = 0;
        done_cnt  = 0;
        mode      = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 1000 && hs_cnt < 300; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (out_valid && out_ready) hs_cnt++;
        end
        chk("srst_reached_300", 64'(hs_cnt), 64'd300);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        out_ready = 1'b0;
        chk("srst_outputs", {out_valid, busy, done, rom_addr, out_idx_a, out_idx_b, out_layer},
            64'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        chk("srst_no_done", 64'(done_cnt), 64'd0);

        run_xfer(1'b0, 0, 0);
        chk("restart_first", 64'(cap[0]), 64'({8'd0, 8'd128, 3'd0, 16'h0001}));
        chk("restart_count", 64'(hs_cnt), 64'd896);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_twiddle_sequencer.md
Name: ntt_twiddle_sequencer

Overview:
- Read-side companion to the registered 128-entry twiddle ROM (7-bit address, 16-bit data, one-cycle latency) used by the Kyber NTT datapath.
- Walks the 7-layer Cooley-Tukey (forward) or Gentleman-Sande (inverse) schedule over 256 coefficients and drives the ROM address.
- Emits one butterfly descriptor per handshake to the butterfly unit: coefficient pair indices, layer, and twiddle.

Parameters:
- TW_W, 16, twiddle/ROM data width.
- IDX_W, 8, coefficient index width (256 coefficients).
- AW, 7, ROM address width.

Ports:
- clk  in  1  clock
- srst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a transform; ignored unless IDLE
- mode  in  1  0 = forward NTT, 1 = inverse NTT; sampled on accepted start
- rom_addr  out  AW  twiddle ROM address
- rom_dout  in  TW_W  ROM registered data, valid one cycle after rom_addr
- out_valid  out  1  descriptor valid
- out_ready  in  1  butterfly unit accepts descriptor
- out_idx_a  out  IDX_W  first coefficient index
- out_idx_b  out  IDX_W  second coefficient index, equal to idx_a + len
- out_layer  out  3  layer 0..6 in issue order
- out_tw  out  TW_W  twiddle for this butterfly
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset and IDLE values: out_valid=0, busy=0, done=0, rom_addr=0, idx/layer outputs=0. out_tw follows the out_tw rule below.
- Counters:
  - layer (3b), group start (8b), offset j (8b), k (7b).
  - len = 128>>layer when forward; 2<<layer when inverse.
- Forward schedule:
  - k starts at 1 and increments at each group end.
  - Groups run start = 0, 2len, ... < 256.
  - Within a group, j runs 0..len-1.
  - idx_a = start+j, idx_b = start+j+len.
- Inverse schedule:
  - k starts at 127 and decrements at each group end.
  - Groups and j are traversed as in forward, with len growing per layer.
- Twiddle: rom_addr = k.
- Totals: 7 layers × 128 butterflies = 896 descriptors; k spans exactly 1..127.
- FSM:
  - IDLE: start accepted -> PRIME. rom_addr is driven with the first k; busy=1.
  - PRIME: one cycle, waiting for ROM data -> RUN with out_valid=1. First descriptor appears two cycles after start.
  - RUN: a handshake (out_valid & out_ready) advances the counters.
    - On a handshake of the 896th descriptor -> DONE and out_valid=0.
  - DONE: one cycle with done=1 -> IDLE, busy=0.
- ROM stall coherence:
  - rom_addr is a mux: the next k when a handshake occurs this cycle, otherwise the current k.
  - This keeps rom_dout aligned with the presented descriptor under arbitrary backpressure.
  - There is a combinational path from out_ready to rom_addr; the ROM's registered output breaks it.
- While out_valid=1 and out_ready=0, all outputs hold stable.
- out_ready may be high continuously, giving one descriptor per cycle with no bubbles, including across group and layer boundaries.
- start during PRIME, RUN or DONE is ignored; mode changes mid-run are ignored.
- srst mid-operation: next cycle is IDLE, all outputs at reset values, no done pulse.

Optional Feature:
- Macro: NTT_SEQ_INV_NEG_EN.
- Defined: in inverse mode, out_tw = two's-complement negation of rom_dout (0 - rom_dout, TW_W bits). Forward mode is unchanged.
- Undefined: out_tw = rom_dout in both modes; the datapath handles the sign.

Decomposition:
- Shared package ntt_pkg:
  - N_COEF=256, N_LAYERS=7, N_BFLY=896, K_FWD_INIT=1, K_INV_INIT=127.
  - FSM state enum (IDLE, PRIME, RUN, DONE).
  - mode constants MODE_FWD/MODE_INV.
- One natural sub-module, ntt_sched_counter: the layer/start/j/k counter set with advance input, last-descriptor flag and mode-dependent len.
- The top level holds the FSM, rom_addr mux and output staging.

Test Plan:
- Bench ROM model: registered, returns {9'h0, addr}.
- Forward, out_ready=1: start at cycle 0.
  - out_valid rises at cycle 2, first descriptor (0,128,layer 0,tw=0x0001).
  - Descriptor 129 is (0,64,layer 1,tw=0x0002).
  - Last descriptor is (253,255,layer 6,tw=0x007F).
  - done pulses one cycle after handshake 896; exactly 896 handshakes.
- Inverse, out_ready=1:
  - First descriptor is (0,2,layer 0,tw=0x007F); second is (1,3).
  - Last descriptor is (127,255,layer 6,tw=0x0001).
  - With NTT_SEQ_INV_NEG_EN the first tw is 0xFF81.
- Random out_ready backpressure (50%):
  - Every accepted descriptor's tw equals the expected k.
  - Outputs stay stable during stalls; the descriptor sequence is identical to the no-stall run.
- start pulsed during RUN and again during DONE: ignored; the count stays 896 and there is a single done pulse.
- srst asserted at handshake 300: outputs return to reset values next cycle with no done pulse. A fresh forward start then reproduces the first descriptor (0,128,0,0x0001).
- Group/layer boundary, forward: handshake 128 -> 129 gives k 1 -> 2 and len 128 -> 64 with no bubble cycle.
